// File: rtl/adc_capture_pkg.sv
// Shared widths and FSM state type for the ADC capture controller.
package adc_capture_pkg;

  localparam int unsigned ADC_DATA_W = 14;
  localparam int unsigned NUM_W      = 16;
  localparam int unsigned DECIM_W    = 8;
  localparam int unsigned AVG_LOG2_W = 3;
  localparam int unsigned AVG_CNT_W  = 7;
  localparam int unsigned ACC_W      = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous sample FIFO with a registered head; occupancy includes the output register.
module adc_capture_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [ADC_DATA_W-1:0] data_i,
  input  logic                  pop_i,
  output logic [ADC_DATA_W-1:0] data_o,
  output logic                  valid_o,
  output logic                  full_c,
  output logic                  empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADC_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  mem_empty;
  logic                  load;

  always_comb begin
    pop_ok    = valid_o && pop_i;
    full_c    = (count == CNT_W'(DEPTH));
    empty_c   = (count == '0);
    push_ok   = push_i && (!full_c || pop_ok);
    mem_empty = (count == CNT_W'(valid_o));
    load      = !mem_empty && (!valid_o || pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (load) begin
        rd_ptr  <= PTR_W'(rd_ptr + 1'b1);
        data_o  <= mem[rd_ptr];
        valid_o <= 1'b1;
      end else if (pop_ok) begin
        valid_o <= 1'b0;
      end
      count <= CNT_W'(count + CNT_W'(push_ok) - CNT_W'(pop_ok));
    end
  end

  // Storage array carries no reset; only written entries are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: decimation, optional averaging (ADC_CAPTURE_AVG_EN), FIFO output.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [NUM_W-1:0]      num_samples_i,
  input  logic [DECIM_W-1:0]    decim_i,
`ifdef ADC_CAPTURE_AVG_EN
  input  logic [AVG_LOG2_W-1:0] avg_log2_i,
`endif
  input  logic [ADC_DATA_W-1:0] adc_data_i,
  input  logic                  adc_rdy_i,
  output logic [ADC_DATA_W-1:0] sample_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  state_t                state;
  state_t                state_next;
  logic [NUM_W-1:0]      num_q;
  logic [DECIM_W-1:0]    decim_q;
  logic [DECIM_W-1:0]    dec_cnt;
  logic [NUM_W-1:0]      smp_cnt;
  logic                  rdy_run;
  logic                  accept;
  logic                  push_req;
  logic [ADC_DATA_W-1:0] push_data;
  logic                  pop;
  logic                  drop;
  logic                  last_sample;
  logic                  fifo_full;
  logic                  fifo_empty;
`ifdef ADC_CAPTURE_AVG_EN
  logic [AVG_LOG2_W-1:0] avg_q;
  logic [AVG_CNT_W-1:0]  avg_cnt;
  logic [AVG_CNT_W-1:0]  avg_last;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_sum;
`endif

  // Datapath decode: which conversion is kept and whether it produces a FIFO push.
  always_comb begin
    rdy_run = (state == ST_RUN) && adc_rdy_i;
    accept  = rdy_run && (dec_cnt == decim_q);
`ifdef ADC_CAPTURE_AVG_EN
    acc_sum   = acc_q + ACC_W'(adc_data_i);
    avg_last  = AVG_CNT_W'((8'd1 << avg_q) - 8'd1);
    push_req  = accept && (avg_cnt == avg_last);
    push_data = ADC_DATA_W'(acc_sum >> avg_q);
`else
    push_req  = accept;
    push_data = adc_data_i;
`endif
    pop         = sample_valid_o && sample_ready_i;
    drop        = push_req && fifo_full && !pop;
    last_sample = push_req && (num_q != '0) && (NUM_W'(smp_cnt + 1'b1) == num_q);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_i) state_next = ST_RUN;
      ST_RUN:   if (stop_i || last_sample) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      num_q      <= '0;
      decim_q    <= '0;
      dec_cnt    <= '0;
      smp_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
      avg_q      <= '0;
      avg_cnt    <= '0;
      acc_q      <= '0;
`endif
    end else begin
      state  <= state_next;
      busy_o <= (state_next != ST_IDLE);
      done_o <= (state == ST_DRAIN) && (state_next == ST_IDLE);
      if ((state == ST_IDLE) && start_i) begin
        num_q      <= num_samples_i;
        decim_q    <= decim_i;
        dec_cnt    <= '0;
        smp_cnt    <= '0;
        overflow_o <= 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
        avg_q      <= avg_log2_i;
        avg_cnt    <= '0;
        acc_q      <= '0;
`endif
      end else begin
        if (rdy_run) dec_cnt <= accept ? '0 : DECIM_W'(dec_cnt + 1'b1);
        // Dropped samples still count toward the requested total.
        if (push_req) smp_cnt <= NUM_W'(smp_cnt + 1'b1);
        if (drop) overflow_o <= 1'b1;
`ifdef ADC_CAPTURE_AVG_EN
        if (accept) begin
          if (push_req) begin
            acc_q   <= '0;
            avg_cnt <= '0;
          end else begin
            acc_q   <= acc_sum;
            avg_cnt <= AVG_CNT_W'(avg_cnt + 1'b1);
          end
        end
        // An abort throws away any incomplete average.
        if ((state == ST_RUN) && stop_i) begin
          acc_q   <= '0;
          avg_cnt <= '0;
        end
`endif
      end
    end
  end

  adc_capture_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (sample_ready_i),
    .data_o  (sample_o),
    .valid_o (sample_valid_o),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl; averaging case runs when ADC_CAPTURE_AVG_EN is defined.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [15:0] num_samples = '0;
  logic [7:0]  decim = '0;
  logic [2:0]  avg_log2 = '0;
  logic [13:0] adc_data = '0;
  logic        adc_rdy = 1'b0;
  logic [13:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overflow;

  int total = 0;
  int bad = 0;
  logic [13:0] exp_q[$];
  bit rand_ready = 1'b0;

  // Reference model state
  int m_num, m_dec, m_a, m_idx, m_out, m_stored, m_sum, m_n;
  bit m_hold;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .num_samples_i  (num_samples),
    .decim_i        (decim),
`ifdef ADC_CAPTURE_AVG_EN
    .avg_log2_i     (avg_log2),
`endif
    .adc_data_i     (adc_data),
    .adc_rdy_i      (adc_rdy),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .busy_o         (busy),
    .done_o         (done),
    .overflow_o     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_start(input int num, input int dec, input int a, input bit hold);
    m_num = num; m_dec = dec; m_a = a; m_hold = hold;
    m_idx = 0; m_out = 0; m_stored = 0; m_sum = 0; m_n = 0;
    num_samples = 16'(num);
    decim = 8'(dec);
    avg_log2 = 3'(a);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Keep every (dec+1)-th conversion, average groups of 2^a, stop after num outputs.
  task automatic model_conv(input int data);
    if (m_idx % (m_dec + 1) == m_dec) begin
      m_sum += data;
      m_n++;
      if (m_n == (1 << m_a)) begin
        if (m_num == 0 || m_out < m_num) begin
          if (!m_hold || m_stored < DEPTH) begin
            exp_q.push_back(14'(m_sum >> m_a));
            m_stored++;
          end
          m_out++;
        end
        m_sum = 0;
        m_n = 0;
      end
    end
    m_idx++;
  endtask

  task automatic conv(input int data, input bit stop, input int gap);
    adc_data = 14'(data);
    adc_rdy = 1'b1;
    stop_i = stop;
    tick();
    adc_rdy = 1'b0;
    stop_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic cap_conv(input int data, input bit stop, input int gap);
    model_conv(data);
    conv(data, stop, gap);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else tick();
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    chk({name, "_busy_at_done"}, 32'(busy), 0);
    tick();
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(done), 0);
    chk({name, "_all_samples_out"}, exp_q.size(), 0);
    tick();
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks hold-stability.
  bit hold_v = 1'b0;
  logic [13:0] hold_d = '0;
  always @(negedge clk) begin
    if (reset_i) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid_held", 32'(sample_valid), 1);
        chk("stall_data_held", 32'(sample), 32'(hold_d));
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_sample: got %0d expected none", sample);
        end else begin
          chk("sample", 32'(sample), 32'(exp_q.pop_front()));
        end
      end
      hold_v = sample_valid && !sample_ready;
      hold_d = sample;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    tick();
    reset_i = 1'b0;
    tick();

    // Basic capture with first-sample latency
    sample_ready = 1'b1;
    model_start(4, 0, 0, 1'b0);
    model_conv(100);
    adc_data = 14'd100;
    adc_rdy = 1'b1;
    tick();
    adc_rdy = 1'b0;
    @(negedge clk);
    chk("latency_1cyc", 32'(sample_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency_2cyc", 32'(sample_valid), 1);
    @(posedge clk);
    #1;
    for (int i = 101; i <= 103; i++) cap_conv(i, 1'b0, 0);
    wait_done("basic");

    // Conversions in IDLE are ignored
    for (int i = 0; i < 3; i++) conv(500 + i, 1'b0, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("idle_rdy_ignored", 32'(sample_valid), 0);
    tick();

    // Decimation
    model_start(3, 2, 0, 1'b0);
    for (int i = 0; i < 9; i++) cap_conv(i, 1'b0, 1);
    wait_done("decim");

    // Overflow with stalled consumer
    sample_ready = 1'b0;
    model_start(10, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) cap_conv(200 + i, 1'b0, 0);
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_busy", 32'(busy), 1);
    chk("ovf_valid", 32'(sample_valid), 1);
    tick();
    sample_ready = 1'b1;
    wait_done("overflow");
    model_start(1, 0, 0, 1'b0);
    @(negedge clk);
    chk("ovf_cleared_on_start", 32'(overflow), 0);
    tick();
    cap_conv(7, 1'b0, 0);
    wait_done("after_ovf");

    // Continuous mode with stop on the last conversion
    model_start(0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) cap_conv(1000 + i * 3, i == 19, 1);
    wait_done("continuous_stop");

    // Reset mid-run with buffered samples
    sample_ready = 1'b0;
    model_start(0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cap_conv(300 + i, 1'b0, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("pre_reset_valid", 32'(sample_valid), 1);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrun_rst_valid", 32'(sample_valid), 0);
    chk("midrun_rst_busy", 32'(busy), 0);
    tick();
    sample_ready = 1'b1;
    model_start(2, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) cap_conv(40 + i, 1'b0, 0);
    wait_done("post_reset");

    // Randomized captures with random backpressure, never exceeding FIFO depth
    for (int t = 0; t < 6; t++) begin
      int dec, num;
      dec = int'($urandom_range(0, 3));
      num = int'($urandom_range(1, DEPTH));
      rand_ready = 1'b1;
      model_start(num, dec, 0, 1'b0);
      for (int k = 0; k < num * (dec + 1); k++)
        cap_conv(int'($urandom_range(0, 16383)), 1'b0, int'($urandom_range(0, 2)));
      wait_done("random");
      rand_ready = 1'b0;
      sample_ready = 1'b1;
      @(negedge clk);
      chk("random_no_overflow", 32'(overflow), 0);
      tick();
    end

`ifdef ADC_CAPTURE_AVG_EN
    // Averaging of four conversions
    model_start(1, 0, 2, 1'b0);
    for (int i = 10; i <= 13; i++) cap_conv(i, 1'b0, 0);
    wait_done("average");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk_i, input, 1, single system clock (PLL output); all logic on rising edge.
REQ-003 SHALL have port reset_i, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1, single-cycle capture start request.
REQ-005 SHALL have port stop_i, input, 1, single-cycle capture abort request.
REQ-006 SHALL have port num_samples_i, input, 16, samples per capture; 0 means continuous.
REQ-007 SHALL have port decim_i, input, 8, decimation; keep one of every decim_i+1 conversions.
REQ-008 SHALL have port adc_data_i, input, 14, conversion result from the SA ADC core.
REQ-009 SHALL have port adc_rdy_i, input, 1, one-cycle pulse marking adc_data_i valid.
REQ-010 SHALL have port sample_o, output, 14, FIFO head sample.
REQ-011 SHALL have port sample_valid_o, output, 1, sample_o valid.
REQ-012 SHALL have port sample_ready_i, input, 1, consumer accepts sample_o.
REQ-013 SHALL have ports busy_o (1, state != IDLE), done_o (1, end-of-capture pulse) and overflow_o (1, sticky drop flag), all outputs.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN.
REQ-015 SHALL in IDLE, on start_i, latch num_samples_i and decim_i, clear decimation and sample counters, clear overflow_o, enter RUN.
REQ-016 SHALL in RUN, on each adc_rdy_i, accept the sample when the decimation counter equals latched decim, then reset that counter; otherwise increment it.
REQ-017 SHALL push each accepted sample into the FIFO; if FIFO full with no simultaneous pop, drop it and set overflow_o.
REQ-018 SHALL count dropped samples toward num_samples; on reaching a nonzero latched count, enter DRAIN next cycle.
REQ-019 SHALL on stop_i in RUN enter DRAIN; a sample accepted in the same cycle as stop_i is still pushed.
REQ-020 SHALL ignore start_i outside IDLE, stop_i outside RUN, and adc_rdy_i outside RUN.
REQ-021 SHALL in DRAIN return to IDLE once FIFO is empty, pulsing done_o high for exactly one cycle on that transition.
REQ-022 SHALL transfer a sample when sample_valid_o and sample_ready_i are both high; sample_o stays stable while valid and not ready.
REQ-023 SHALL produce sample_valid_o 2 cycles after an accepting adc_rdy_i when the FIFO is empty.
REQ-024 SHALL accept simultaneous push and pop when full without overflow; counters wrap modulo FIFO_DEPTH.

Reset
REQ-025 SHALL on reset_i, including mid-capture, enter IDLE, empty the FIFO, clear all counters, and drive sample_o=0, sample_valid_o=0, busy_o=0, done_o=0, overflow_o=0.

Configuration
REQ-026 SHALL, with ADC_CAPTURE_AVG_EN defined, add input avg_log2_i (3 bits, latched at start). Each pushed sample is the sum of 2^avg_log2_i accepted samples in an 21-bit accumulator, shifted right by avg_log2_i and truncated to 14 bits. num_samples counts averaged outputs.
REQ-027 SHALL, without ADC_CAPTURE_AVG_EN, omit avg_log2_i and the accumulator; every accepted sample is pushed directly.
REQ-028 SHALL, with ADC_CAPTURE_AVG_EN defined, discard a partial average when stop_i enters DRAIN.

Structure
REQ-029 SHALL place ADC_DATA_W=14, the state enum and accumulator width in shared package adc_capture_pkg.
REQ-030 SHALL implement the FIFO as sub-module adc_capture_fifo (synchronous, full/empty flags, registered output).

Verification
REQ-031 SHALL test: num_samples=4, decim=0, data 100..103 on 4 rdy pulses, ready=1 -> outputs 100,101,102,103, then done_o one pulse, busy_o=0.
REQ-032 SHALL test: num_samples=3, decim=2, 9 rdy pulses with data 0..8 -> outputs 2,5,8 only.
REQ-033 SHALL test: FIFO_DEPTH=8, ready=0, num_samples=10, decim=0 -> first 8 stored, overflow_o=1, then ready=1 drains 8 samples and done_o pulses.
REQ-034 SHALL test: num_samples=0, 20 rdy pulses, stop_i coincident with 20th -> 20 samples output, then done_o.
REQ-035 SHALL test: reset_i mid-RUN with 3 samples buffered -> next cycle sample_valid_o=0, busy_o=0, and a following start_i captures normally.
REQ-036 SHALL test with ADC_CAPTURE_AVG_EN: avg_log2=2, num_samples=1, data 10,11,12,13 -> single output 11.
